fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Redirects flush IF/ID, and the first misaligned redirect target is latched for diagnosis.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_data,
    output logic [9:0]  imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        addr_err,
    output logic [31:0] err_pc,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic        r_addr_err;
    logic [31:0] r_err_pc;
    logic [31:0] r_fetch_count;

    logic        w_advance;
    logic        w_misaligned;
    logic [31:0] w_pc4;
    logic [31:0] w_target;

    assign w_advance    = !redirect && !stall;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_pc4        = r_pc + 32'd4;
    assign w_target     = {redirect_pc[31:2], 2'b00};

    // PC and IF/ID register; redirect wins over stall and flushes the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_id_instr    <= 32'h0000_0000;
            r_id_pc4      <= 32'h0000_0000;
            r_id_valid    <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else if (redirect) begin
            r_pc          <= w_target;
            r_id_instr    <= 32'h0000_0000;
            r_id_pc4      <= 32'h0000_0000;
            r_id_valid    <= 1'b0;
        end else if (w_advance) begin
            r_pc          <= w_pc4;
            r_id_instr    <= imem_data;
            r_id_pc4      <= w_pc4;
            r_id_valid    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Sticky capture of the first misaligned target; later faults are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_err <= 1'b0;
            r_err_pc   <= 32'h0000_0000;
        end else if (redirect && w_misaligned && !r_addr_err) begin
            r_addr_err <= 1'b1;
            r_err_pc   <= redirect_pc;
        end
    end

    assign imem_addr   = r_pc[11:2];
    assign pc          = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc4      = r_id_pc4;
    assign id_valid    = r_id_valid;
    assign addr_err    = r_addr_err;
    assign err_pc      = r_err_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_data;
    logic [9:0]  imem_addr;
    logic [31:0] pc, id_instr, id_pc4, err_pc, fetch_count;
    logic        id_valid, addr_err;

    logic [31:0] mem [1024];

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Reference model state
    logic [31:0] m_pc    = 32'h0000_3000;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4   = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_errpc = 32'h0;
    logic [31:0] m_cnt   = 32'h0;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .addr_err    (addr_err),
        .err_pc      (err_pc),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: next state from the rules, then compare 1 time unit later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0000_3000; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_err = 0; m_errpc = 0; m_cnt = 0;
        end else if (redirect) begin
            if (redirect_pc % 4 != 0 && !m_err) begin
                m_err = 1'b1;
                m_errpc = redirect_pc;
            end
            m_pc = redirect_pc - (redirect_pc % 4);
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!stall) begin
            m_instr = mem[(m_pc / 4) % 1024];
            m_pc = m_pc + 4;
            m_pc4 = m_pc;
            m_valid = 1'b1;
            m_cnt = m_cnt + 1;
        end
        #1;
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", {22'd0, imem_addr}, (m_pc / 4) % 1024);
            chk("id_instr", id_instr, m_instr);
            chk("id_pc4", id_pc4, m_pc4);
            chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
            chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
            chk("err_pc", err_pc, m_errpc);
            chk("fetch_count", fetch_count, m_cnt);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2008_0005;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(2);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk_en = 1'b1;

        // Sequential fetch
        reset = 1'b0;
        tick(3);
        chk("seq_pc", pc, 32'h0000_300C);
        chk("seq_imem_addr", {22'd0, imem_addr}, 32'd3);
        chk("seq_id_pc4", id_pc4, 32'h0000_300C);
        chk("seq_id_valid", {31'd0, id_valid}, 32'd1);
        chk("seq_id_instr", id_instr, 32'h2008_0005);
        chk("seq_fetch_count", fetch_count, 32'd3);

        // Stall holds everything
        redirect = 1'b1; redirect_pc = 32'h0000_3000;
        tick(1);
        redirect = 1'b0;
        tick(1);
        chk("pre_stall_pc", pc, 32'h0000_3004);
        stall = 1'b1;
        tick(4);
        chk("stall_pc", pc, 32'h0000_3004);
        chk("stall_id_instr", id_instr, 32'h2008_0005);
        chk("stall_fetch_count", fetch_count, 32'd4);
        stall = 1'b0;
        tick(1);
        chk("unstall_pc", pc, 32'h0000_3008);
        chk("unstall_fetch_count", fetch_count, 32'd5);

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;

        // Redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3040;
        tick(1);
        chk("rdst_pc", pc, 32'h0000_3040);
        chk("rdst_imem_addr", {22'd0, imem_addr}, 32'd16);
        chk("rdst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rdst_id_instr", id_instr, 32'h0);
        chk("rdst_fetch_count", fetch_count, 32'd5);
        stall = 1'b0; redirect = 1'b0;
        tick(2);
        chk("after_rd_pc", pc, 32'h0000_3048);
        chk("after_rd_instr", id_instr, 32'hC0DE_0011);

        // Misaligned targets: first one is captured, second ignored
        redirect = 1'b1; redirect_pc = 32'h0000_3022;
        tick(1);
        chk("mis1_addr_err", {31'd0, addr_err}, 32'd1);
        chk("mis1_err_pc", err_pc, 32'h0000_3022);
        chk("mis1_pc", pc, 32'h0000_3020);
        redirect = 1'b0;
        tick(1);
        redirect = 1'b1; redirect_pc = 32'h0000_3011;
        tick(1);
        chk("mis2_err_pc", err_pc, 32'h0000_3022);
        chk("mis2_pc", pc, 32'h0000_3010);
        chk("mis2_addr_err", {31'd0, addr_err}, 32'd1);

        // PC wrap
        redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        tick(1);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_imem_addr", {22'd0, imem_addr}, 32'd0);
        chk("wrap_id_pc4", id_pc4, 32'h0);
        chk("wrap_id_valid", {31'd0, id_valid}, 32'd1);
        chk("wrap_id_instr", id_instr, 32'hC0DE_03FF);
        chk("wrap_fetch_count", fetch_count, 32'd9);

        // Asynchronous reset mid-stall, between edges
        redirect = 1'b1; redirect_pc = 32'h0000_3100;
        tick(1);
        redirect = 1'b0; stall = 1'b1;
        chk("pre_arst_pc", pc, 32'h0000_3100);
        chk("pre_arst_addr_err", {31'd0, addr_err}, 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0000_3000);
        chk("arst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_fetch_count", fetch_count, 32'd0);
        chk("arst_err_pc", err_pc, 32'd0);

        // Requests while reset is held are discarded
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_3202;
        tick(2);
        chk("hold_pc", pc, 32'h0000_3000);
        chk("hold_addr_err", {31'd0, addr_err}, 32'd0);

        // First fetch after reset comes from RESET_PC
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        tick(1);
        chk("post_rst_pc", pc, 32'h0000_3004);
        chk("post_rst_id_pc4", id_pc4, 32'h0000_3004);
        chk("post_rst_id_instr", id_instr, 32'hC0DE_0000);
        chk("post_rst_fetch_count", fetch_count, 32'd1);
        tick(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
